// File: rtl/game_pkg.sv
// game_pkg: shared tile/board types, direction encodings, controller state encoding.
`default_nettype none

package game_pkg;

  localparam int GAME_W = 12;

  typedef logic [GAME_W-1:0] tile_t;
  typedef tile_t [3:0][3:0]  board_t;

  localparam logic [3:0] DIR_UP    = 4'b1000;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b0010;
  localparam logic [3:0] DIR_RIGHT = 4'b0001;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_INIT     = 3'd1,
    S_WAIT_DIR = 3'd2,
    S_LAUNCH   = 3'd3,
    S_COMMIT   = 3'd4,
    S_SPAWN    = 3'd5,
    S_CHECK    = 3'd6,
    S_OVER     = 3'd7
  } state_t;

  function automatic logic is_dir(input logic [3:0] d);
    return (d == DIR_UP) || (d == DIR_DOWN) || (d == DIR_LEFT) || (d == DIR_RIGHT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/game_board_checker.sv
// game_board_checker: combinational board status - per-cell empty flags,
// any empty cell, any equal orthogonal neighbour pair, any winning tile.
`default_nettype none

module game_board_checker #(
  parameter int W         = 12,
  parameter int WIN_VALUE = 2048
) (
  input  logic [16*W-1:0] i_board,
  output logic [15:0]     o_empty,
  output logic            o_any_empty,
  output logic            o_has_merge,
  output logic            o_has_win
);

  logic [15:0] w_win;
  logic [15:0] w_merge;

  // Cell i sits at row i/4, column i%4; compare each cell with its right and lower neighbour.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_cell
      logic [W-1:0] w_cur;
      logic         w_eq_right;
      logic         w_eq_down;

      assign w_cur        = i_board[gi*W +: W];
      assign o_empty[gi]  = (w_cur == '0);
      assign w_win[gi]    = (w_cur == W'(WIN_VALUE));

      if ((gi % 4) != 3) begin : g_right
        assign w_eq_right = (w_cur == i_board[(gi+1)*W +: W]);
      end else begin : g_no_right
        assign w_eq_right = 1'b0;
      end

      if (gi < 12) begin : g_down
        assign w_eq_down = (w_cur == i_board[(gi+4)*W +: W]);
      end else begin : g_no_down
        assign w_eq_down = 1'b0;
      end

      assign w_merge[gi] = w_eq_right | w_eq_down;
    end
  endgenerate

  assign o_any_empty = |o_empty;
  assign o_has_merge = |w_merge;
  assign o_has_win   = |w_win;

endmodule

`default_nettype wire

// File: rtl/game_move_controller.sv
// game_move_controller: 2048 turn sequencer - owns the board, runs the summation datapath
// handshake, requests tile spawns and flags win/lose. Optional one-level undo: GAME_UNDO_EN.
`default_nettype none

module game_move_controller
  import game_pkg::*;
#(
  parameter int W           = GAME_W,
  parameter int WIN_VALUE   = 2048,
  parameter int SUM_TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_new_game,
`ifdef GAME_UNDO_EN
  input  logic            i_undo,
`endif
  input  logic            i_dir_valid,
  input  logic [3:0]      i_direction,
  output logic            o_dir_ready,
  output logic            o_sum_enable,
  output logic [3:0]      o_sum_dir,
  output logic [16*W-1:0] o_sum_matrix,
  input  logic [16*W-1:0] i_sum_result,
  input  logic            i_sum_ready,
  output logic            o_sum_clr,
  output logic            o_spawn_req,
  input  logic            i_spawn_ack,
  input  logic [3:0]      i_spawn_pos,
  input  logic [W-1:0]    i_spawn_val,
  output logic [16*W-1:0] o_board,
  output logic            o_win,
  output logic            o_lose,
  output logic            o_move_err
);

  localparam int TW = (SUM_TIMEOUT > 2) ? $clog2(SUM_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(SUM_TIMEOUT - 1);

  state_t          r_state;
  logic [16*W-1:0] r_board;
  logic [16*W-1:0] r_result;
  logic [TW-1:0]   r_tcnt;
  logic            r_spawn_extra;
  logic            r_ng_pending;
  logic            r_dir_ready;
  logic            r_sum_enable;
  logic [3:0]      r_sum_dir;
  logic            r_sum_clr;
  logic            r_spawn_req;
  logic            r_win;
  logic            r_lose;
  logic            r_move_err;
`ifdef GAME_UNDO_EN
  logic [16*W-1:0] r_shadow;
`endif

  logic [15:0] w_empty;
  logic        w_any_empty;
  logic        w_has_merge;
  logic        w_has_win;
  logic        w_result_empty;

  game_board_checker #(
    .W         (W),
    .WIN_VALUE (WIN_VALUE)
  ) u_checker (
    .i_board     (r_board),
    .o_empty     (w_empty),
    .o_any_empty (w_any_empty),
    .o_has_merge (w_has_merge),
    .o_has_win   (w_has_win)
  );

  // Decides at COMMIT whether a spawn request is worth raising for the new board.
  always_comb begin
    w_result_empty = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (r_result[i*W +: W] == '0) w_result_empty = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_board       <= '0;
      r_result      <= '0;
      r_tcnt        <= '0;
      r_spawn_extra <= 1'b0;
      r_ng_pending  <= 1'b0;
      r_dir_ready   <= 1'b0;
      r_sum_enable  <= 1'b0;
      r_sum_dir     <= '0;
      r_sum_clr     <= 1'b0;
      r_spawn_req   <= 1'b0;
      r_win         <= 1'b0;
      r_lose        <= 1'b0;
      r_move_err    <= 1'b0;
`ifdef GAME_UNDO_EN
      r_shadow      <= '0;
`endif
    end else begin
      r_sum_clr  <= 1'b0;
      r_move_err <= 1'b0;
      // A move in flight must finish before new_game takes effect.
      if (i_new_game && (r_state != S_LAUNCH) && (r_state != S_COMMIT)) begin
        r_state     <= S_INIT;
        r_dir_ready <= 1'b0;
        r_spawn_req <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: ;
          S_INIT: begin
            r_board       <= '0;
            r_win         <= 1'b0;
            r_lose        <= 1'b0;
            r_ng_pending  <= 1'b0;
            r_spawn_extra <= 1'b1;
            r_spawn_req   <= 1'b1;
            r_state       <= S_SPAWN;
          end
          S_WAIT_DIR: begin
`ifdef GAME_UNDO_EN
            if (i_undo) begin
              r_board <= r_shadow;
              r_win   <= 1'b0;
              r_lose  <= 1'b0;
            end else
`endif
            if (i_dir_valid && is_dir(i_direction)) begin
              r_sum_dir    <= i_direction;
              r_sum_enable <= 1'b1;
              r_tcnt       <= '0;
              r_dir_ready  <= 1'b0;
              r_state      <= S_LAUNCH;
            end
          end
          S_LAUNCH: begin
            r_ng_pending <= r_ng_pending | i_new_game;
            if (i_sum_ready) begin
              r_result     <= i_sum_result;
              r_sum_enable <= 1'b0;
              r_sum_clr    <= 1'b1;
              r_state      <= S_COMMIT;
            end else if (r_tcnt == TMAX) begin
              r_sum_enable <= 1'b0;
              r_sum_clr    <= 1'b1;
              r_move_err   <= 1'b1;
              if (r_ng_pending || i_new_game) begin
                r_ng_pending <= 1'b0;
                r_state      <= S_INIT;
              end else begin
                r_dir_ready <= 1'b1;
                r_state     <= S_WAIT_DIR;
              end
            end else begin
              r_tcnt <= r_tcnt + 1'b1;
            end
          end
          S_COMMIT: begin
            r_ng_pending <= 1'b0;
            if (r_ng_pending || i_new_game) begin
              r_state <= S_INIT;
            end else if (r_result == r_board) begin
              r_dir_ready <= 1'b1;
              r_state     <= S_WAIT_DIR;
            end else begin
`ifdef GAME_UNDO_EN
              r_shadow <= r_board;
`endif
              r_board       <= r_result;
              r_spawn_extra <= 1'b0;
              r_spawn_req   <= w_result_empty;
              r_state       <= S_SPAWN;
            end
          end
          S_SPAWN: begin
            if (!w_any_empty) begin
              r_spawn_req   <= 1'b0;
              r_spawn_extra <= 1'b0;
              r_state       <= S_CHECK;
            end else if (i_spawn_ack && r_spawn_req && w_empty[i_spawn_pos]) begin
              r_board[i_spawn_pos*W +: W] <= i_spawn_val;
              if (r_spawn_extra) begin
                r_spawn_extra <= 1'b0;
              end else begin
                r_spawn_req <= 1'b0;
                r_state     <= S_CHECK;
              end
            end
          end
          S_CHECK: begin
            if (w_has_win) begin
              r_win   <= 1'b1;
              r_state <= S_OVER;
            end else if (!w_any_empty && !w_has_merge) begin
              r_lose  <= 1'b1;
              r_state <= S_OVER;
            end else begin
              r_dir_ready <= 1'b1;
              r_state     <= S_WAIT_DIR;
            end
          end
          S_OVER: ;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_dir_ready  = r_dir_ready;
  assign o_sum_enable = r_sum_enable;
  assign o_sum_dir    = r_sum_dir;
  assign o_sum_matrix = r_board;
  assign o_sum_clr    = r_sum_clr;
  assign o_spawn_req  = r_spawn_req;
  assign o_board      = r_board;
  assign o_win        = r_win;
  assign o_lose       = r_lose;
  assign o_move_err   = r_move_err;

endmodule

`default_nettype wire

// File: tb/tb_game_move_controller.sv
// tb_game_move_controller: directed-vector bench; the bench plays the datapath and spawn source.
`default_nettype none

module tb_game_move_controller;

  localparam int W = 12;

  logic            clk;
  logic            rst_n;
  logic            i_new_game;
  logic            i_dir_valid;
  logic [3:0]      i_direction;
  logic            o_dir_ready;
  logic            o_sum_enable;
  logic [3:0]      o_sum_dir;
  logic [16*W-1:0] o_sum_matrix;
  logic [16*W-1:0] i_sum_result;
  logic            i_sum_ready;
  logic            o_sum_clr;
  logic            o_spawn_req;
  logic            i_spawn_ack;
  logic [3:0]      i_spawn_pos;
  logic [W-1:0]    i_spawn_val;
  logic [16*W-1:0] o_board;
  logic            o_win;
  logic            o_lose;
  logic            o_move_err;

  int n_checks;
  int n_fail;

  logic [16*W-1:0] exp_b;
  logic [16*W-1:0] res_b;

  game_move_controller #(.W(W), .WIN_VALUE(2048), .SUM_TIMEOUT(64)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_new_game   (i_new_game),
    .i_dir_valid  (i_dir_valid),
    .i_direction  (i_direction),
    .o_dir_ready  (o_dir_ready),
    .o_sum_enable (o_sum_enable),
    .o_sum_dir    (o_sum_dir),
    .o_sum_matrix (o_sum_matrix),
    .i_sum_result (i_sum_result),
    .i_sum_ready  (i_sum_ready),
    .o_sum_clr    (o_sum_clr),
    .o_spawn_req  (o_spawn_req),
    .i_spawn_ack  (i_spawn_ack),
    .i_spawn_pos  (i_spawn_pos),
    .i_spawn_val  (i_spawn_val),
    .o_board      (o_board),
    .o_win        (o_win),
    .o_lose       (o_lose),
    .o_move_err   (o_move_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_dir_ready(input string tag);
    int n = 0;
    while (!o_dir_ready && n < 30) begin
      tick();
      n++;
    end
    if (!o_dir_ready) chk({tag, "_dir_ready_timeout"}, 0, 1);
  endtask

  task automatic wait_spawn_req(input string tag);
    int n = 0;
    while (!o_spawn_req && n < 30) begin
      tick();
      n++;
    end
    if (!o_spawn_req) chk({tag, "_spawn_req_timeout"}, 0, 1);
  endtask

  task automatic do_spawn(input logic [3:0] pos, input logic [W-1:0] val);
    wait_spawn_req("spawn");
    i_spawn_ack = 1'b1;
    i_spawn_pos = pos;
    i_spawn_val = val;
    tick();
    i_spawn_ack = 1'b0;
  endtask

  task automatic launch(input logic [3:0] d);
    wait_dir_ready("launch");
    i_dir_valid = 1'b1;
    i_direction = d;
    tick();
    i_dir_valid = 1'b0;
    chk("launch_sum_enable", o_sum_enable, 1);
  endtask

  task automatic respond(input logic [16*W-1:0] r);
    i_sum_ready  = 1'b1;
    i_sum_result = r;
    tick();
    i_sum_ready  = 1'b0;
    chk("commit_sum_clr", o_sum_clr, 1);
  endtask

  task automatic new_game_pulse();
    i_new_game = 1'b1;
    tick();
    i_new_game = 1'b0;
  endtask

  initial begin
    int n;
    n_checks = 0;
    n_fail = 0;
    rst_n = 1'b0;
    i_new_game = 0; i_dir_valid = 0; i_direction = 0;
    i_sum_result = '0; i_sum_ready = 0;
    i_spawn_ack = 0; i_spawn_pos = 0; i_spawn_val = 0;
    #22;
    chk("rst_dir_ready", o_dir_ready, 0);
    chk("rst_outputs", {o_sum_enable, o_sum_clr, o_spawn_req, o_win, o_lose, o_move_err}, 0);
    chk("rst_board", o_board, 0);
    rst_n = 1'b1;
    tick(); tick();
    chk("idle_dir_ready", o_dir_ready, 0);

    // New game: spawns (0,2) and (5,4)
    new_game_pulse();
    do_spawn(4'd0, 12'd2);
    do_spawn(4'd5, 12'd4);
    wait_dir_ready("init");
    exp_b = '0; exp_b[0*W +: W] = 2; exp_b[5*W +: W] = 4;
    chk("init_board", o_board, exp_b);
    chk("init_dir_ready", o_dir_ready, 1);

    // Move left with a 2-cycle datapath; occupied ack ignored during spawn
    launch(4'b0010);
    chk("move1_sum_dir", o_sum_dir, 4'b0010);
    chk("move1_sum_matrix", o_sum_matrix, exp_b);
    tick(); tick();
    chk("move1_enable_held", o_sum_enable, 1);
    res_b = '0; res_b[0*W +: W] = 2; res_b[4*W +: W] = 4;
    respond(res_b);
    chk("move1_enable_drop", o_sum_enable, 0);
    tick();
    chk("move1_sum_clr_pulse", o_sum_clr, 0);
    chk("move1_spawn_req", o_spawn_req, 1);
    chk("move1_board", o_board, res_b);
    i_spawn_ack = 1'b1; i_spawn_pos = 4'd0; i_spawn_val = 12'd4;
    tick();
    i_spawn_ack = 1'b0;
    chk("occupied_ack_req_held", o_spawn_req, 1);
    chk("occupied_ack_board", o_board, res_b);
    do_spawn(4'd1, 12'd2);
    wait_dir_ready("move1");
    exp_b = res_b; exp_b[1*W +: W] = 2;
    chk("move1_final_board", o_board, exp_b);

    // Row0 {2,2,0,0} merges to {4,0,0,0}
    launch(4'b0010);
    res_b = '0; res_b[0*W +: W] = 4; res_b[4*W +: W] = 4;
    respond(res_b);
    do_spawn(4'd15, 12'd4);
    wait_dir_ready("move2");
    exp_b = res_b; exp_b[15*W +: W] = 4;
    chk("move2_board", o_board, exp_b);

    // Non-one-hot direction is dropped
    i_dir_valid = 1'b1; i_direction = 4'b0011;
    tick();
    i_dir_valid = 1'b0;
    chk("bad_dir_ready", o_dir_ready, 1);
    chk("bad_dir_no_enable", o_sum_enable, 0);

    // No-op move: no spawn, board unchanged
    launch(4'b1000);
    respond(exp_b);
    tick();
    chk("noop_dir_ready", o_dir_ready, 1);
    chk("noop_no_spawn", o_spawn_req, 0);
    chk("noop_board", o_board, exp_b);

    // Datapath never answers
    launch(4'b0100);
    n = 0;
    while (!o_move_err && n < 200) begin
      tick();
      n++;
    end
    chk("timeout_cycles", n, 64);
    chk("timeout_move_err", o_move_err, 1);
    chk("timeout_sum_clr", o_sum_clr, 1);
    chk("timeout_board", o_board, exp_b);
    chk("timeout_dir_ready", o_dir_ready, 1);
    tick();
    chk("timeout_err_pulse", o_move_err, 0);

    // Win
    launch(4'b0001);
    res_b = '0; res_b[3*W +: W] = 2048; res_b[7*W +: W] = 4;
    respond(res_b);
    do_spawn(4'd0, 12'd2);
    tick();
    chk("win_flag", o_win, 1);
    chk("win_dir_ready", o_dir_ready, 0);
    chk("win_no_lose", o_lose, 0);

    // Restart, then lose on a full checkerboard
    new_game_pulse();
    do_spawn(4'd2, 12'd2);
    do_spawn(4'd8, 12'd4);
    wait_dir_ready("restart");
    chk("restart_win_clear", o_win, 0);
    launch(4'b0010);
    for (int i = 0; i < 16; i++) res_b[i*W +: W] = (((i / 4) + (i % 4)) % 2 == 1) ? 12'd4 : 12'd2;
    respond(res_b);
    tick();
    chk("lose_no_spawn_req", o_spawn_req, 0);
    tick(); tick();
    chk("lose_flag", o_lose, 1);
    chk("lose_no_win", o_win, 0);
    chk("lose_dir_ready", o_dir_ready, 0);

    // new_game during LAUNCH waits for COMMIT
    new_game_pulse();
    do_spawn(4'd0, 12'd2);
    do_spawn(4'd1, 12'd2);
    launch(4'b0010);
    new_game_pulse();
    chk("pending_enable_held", o_sum_enable, 1);
    res_b = '0; res_b[0*W +: W] = 4;
    respond(res_b);
    wait_spawn_req("pending");
    chk("pending_board_cleared", o_board, 0);
    do_spawn(4'd6, 12'd2);
    do_spawn(4'd9, 12'd2);

    // Async reset during LAUNCH
    launch(4'b1000);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_outputs", {o_sum_enable, o_dir_ready, o_spawn_req, o_sum_clr, o_win, o_lose}, 0);
    chk("async_rst_board", o_board, 0);
    #3 rst_n = 1'b1;
    tick();
    chk("post_rst_idle", o_dir_ready, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
